fullchip_seq: RTL and testbench

Instruction sequencer for the attention core `fullchip`. It replaces bench-driven instruction stepping with a registered state machine that emits the 19-bit `inst` word and the `mem_in` bus. One run streams Q vectors into qmem and K vectors into kmem from a valid/ready host port, then loads K, executes, drains, accumulates ofifo into SFP, and normalises into pmem. It sits directly between the host/DMA and `fullchip`.

---
 rtl/fullchip_pkg.sv | 45 ++++
 rtl/seq_inst_pack.sv | 27 ++
 rtl/fullchip_seq.sv | 146 ++++++++++++++
 tb/tb_fullchip_seq.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fullchip_pkg.sv
// Shared definitions for the fullchip attention core and its instruction sequencer:
// sequencer states, instruction-word bit positions and field widths.
package fullchip_pkg;

    localparam int INST_W  = 19;
    localparam int ADD_W   = 4;
    localparam int CNT_W   = 5;
    localparam int MAX_VEC = 16;

    localparam int INST_DIV      = 18;
    localparam int INST_ACC      = 17;
    localparam int INST_OFIFO_RD = 16;
    localparam int INST_QK_ADD   = 12;
    localparam int INST_P_ADD    = 8;
    localparam int INST_EXECUTE  = 7;
    localparam int INST_LOAD     = 6;
    localparam int INST_QMEM_RD  = 5;
    localparam int INST_QMEM_WR  = 4;
    localparam int INST_KMEM_RD  = 3;
    localparam int INST_KMEM_WR  = 2;
    localparam int INST_PMEM_RD  = 1;
    localparam int INST_PMEM_WR  = 0;

    typedef enum logic [3:0] {
        S_IDLE, S_WRQ, S_WRK, S_LOADK, S_GAP1, S_EXEC,
        S_GAP2, S_ACC, S_ACCW, S_NORM, S_DONE
    } seq_state_e;

    typedef struct packed {
        logic             div;
        logic             acc;
        logic             ofifo_rd;
        logic [ADD_W-1:0] qkmem_add;
        logic [ADD_W-1:0] pmem_add;
        logic             execute;
        logic             load;
        logic             qmem_rd;
        logic             qmem_wr;
        logic             kmem_rd;
        logic             kmem_wr;
        logic             pmem_rd;
        logic             pmem_wr;
    } inst_fields_t;

endpackage

// File: rtl/seq_inst_pack.sv
// Packs named instruction fields into the 19-bit fullchip instruction word
// using the shared bit-position constants.
module seq_inst_pack
    import fullchip_pkg::*;
(
    input  inst_fields_t      fields,
    output logic [INST_W-1:0] inst
);

    always_comb begin
        inst                             = '0;
        inst[INST_DIV]                   = fields.div;
        inst[INST_ACC]                   = fields.acc;
        inst[INST_OFIFO_RD]              = fields.ofifo_rd;
        inst[INST_QK_ADD +: ADD_W]       = fields.qkmem_add;
        inst[INST_P_ADD +: ADD_W]        = fields.pmem_add;
        inst[INST_EXECUTE]               = fields.execute;
        inst[INST_LOAD]                  = fields.load;
        inst[INST_QMEM_RD]               = fields.qmem_rd;
        inst[INST_QMEM_WR]               = fields.qmem_wr;
        inst[INST_KMEM_RD]               = fields.kmem_rd;
        inst[INST_KMEM_WR]               = fields.kmem_wr;
        inst[INST_PMEM_RD]               = fields.pmem_rd;
        inst[INST_PMEM_WR]               = fields.pmem_wr;
    end

endmodule

// File: rtl/fullchip_seq.sv
// Instruction sequencer for fullchip: streams Q/K vectors from the host, then steps
// load, execute, accumulate and normalise, emitting registered inst and mem_in.
module fullchip_seq
    import fullchip_pkg::*;
#(
    parameter int bw      = 8,
    parameter int pr      = 16,
    parameter int col     = 8,
    parameter int gap_cyc = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [3:0]           q_num,
    input  logic [pr*bw-1:0]     in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [pr*bw-1:0]     mem_in,
    output logic [INST_W-1:0]    inst,
    output logic                 busy,
    output logic                 done
);

    localparam int DW = pr * bw;
    localparam logic [CNT_W-1:0] COL_LAST   = CNT_W'(col - 1);
    localparam logic [CNT_W-1:0] COL_END    = CNT_W'(col);
    localparam logic [CNT_W-1:0] LOADK_LAST = CNT_W'(col + 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(gap_cyc - 1);

    if (col < 1 || col > MAX_VEC || gap_cyc < 1 || gap_cyc > 32) begin : g_bad_cfg
        $error("fullchip_seq: col must be 1..16 and gap_cyc 1..32");
    end

    seq_state_e         state_p0, state_nx;
    logic [CNT_W-1:0]   cnt_p0, cnt_nx;
    logic [CNT_W-1:0]   n_p0, n_nx;
    logic [CNT_W-1:0]   n_last;
    inst_fields_t       fields;
    logic [INST_W-1:0]  inst_c;
    logic               accept;
    logic               load_mem;
    logic [DW-1:0]      mem_in_p1;
    logic [INST_W-1:0]  inst_p1;
    logic               busy_p1;
    logic               done_p1;

    assign in_ready = (state_p0 == S_WRQ) || (state_p0 == S_WRK);
    assign accept   = in_valid & in_ready;
    assign n_last   = n_p0 - CNT_W'(1);

    always_comb begin
        state_nx = state_p0;
        cnt_nx   = cnt_p0 + CNT_W'(1);
        n_nx     = n_p0;
        fields   = '0;
        load_mem = 1'b0;
        case (state_p0)
            S_IDLE: begin
                cnt_nx = '0;
                if (start) begin
                    n_nx     = CNT_W'(q_num) + CNT_W'(1);
                    state_nx = S_WRQ;
                end
            end
            S_WRQ, S_WRK: begin
                cnt_nx = cnt_p0;
                if (accept) begin
                    load_mem         = 1'b1;
                    fields.qkmem_add = cnt_p0[ADD_W-1:0];
                    fields.qmem_wr   = (state_p0 == S_WRQ);
                    fields.kmem_wr   = (state_p0 == S_WRK);
                    cnt_nx           = cnt_p0 + CNT_W'(1);
                    if (state_p0 == S_WRQ && cnt_p0 == n_last) state_nx = S_WRK;
                    if (state_p0 == S_WRK && cnt_p0 == COL_LAST) state_nx = S_LOADK;
                end
            end
            S_LOADK: begin
                fields.load = 1'b1;
                // kmem read data lags the address by a cycle, so reads sit at cnt 1..col
                if (cnt_p0 != '0 && cnt_p0 <= COL_END) begin
                    fields.kmem_rd   = 1'b1;
                    fields.qkmem_add = ADD_W'(cnt_p0 - CNT_W'(1));
                end
                if (cnt_p0 == LOADK_LAST) state_nx = S_GAP1;
            end
            S_GAP1: if (cnt_p0 == GAP_LAST) state_nx = S_EXEC;
            S_EXEC: begin
                fields.execute   = 1'b1;
                fields.qmem_rd   = 1'b1;
                fields.qkmem_add = cnt_p0[ADD_W-1:0];
                if (cnt_p0 == n_last) state_nx = S_GAP2;
            end
            S_GAP2: if (cnt_p0 == GAP_LAST) state_nx = S_ACC;
            S_ACC: begin
                fields.ofifo_rd = 1'b1;
                fields.acc      = 1'b1;
                if (cnt_p0 == n_last) state_nx = S_ACCW;
            end
            S_ACCW: if (cnt_p0 == n_last) state_nx = S_NORM;
            S_NORM: begin
                fields.div = (cnt_p0 <= n_p0);
                // pmem writes trail the divider by two cycles
                if (cnt_p0 >= CNT_W'(2)) begin
                    fields.pmem_wr  = 1'b1;
                    fields.pmem_add = ADD_W'(cnt_p0 - CNT_W'(2));
                end
                if (cnt_p0 == n_p0 + CNT_W'(1)) state_nx = S_DONE;
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
        if (state_nx != state_p0) cnt_nx = '0;
    end

    seq_inst_pack u_pack (
        .fields (fields),
        .inst   (inst_c)
    );

    // Decision edge: state advances and this step's outputs are registered together
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_p0  <= S_IDLE;
            cnt_p0    <= '0;
            n_p0      <= '0;
            inst_p1   <= '0;
            mem_in_p1 <= '0;
            busy_p1   <= 1'b0;
            done_p1   <= 1'b0;
        end else begin
            state_p0 <= state_nx;
            cnt_p0   <= cnt_nx;
            n_p0     <= n_nx;
            inst_p1  <= inst_c;
            if (load_mem) mem_in_p1 <= in_data;
            busy_p1  <= (state_nx != S_IDLE);
            done_p1  <= (state_p0 == S_DONE);
        end
    end

    assign inst   = inst_p1;
    assign mem_in = mem_in_p1;
    assign busy   = busy_p1;
    assign done   = done_p1;

endmodule

// File: tb/tb_fullchip_seq.sv
// Scoreboard bench for fullchip_seq: every non-zero inst word is popped against
// an independently built expected instruction stream.
module tb_fullchip_seq;

    localparam int BW  = 8;
    localparam int PR  = 16;
    localparam int COL = 8;
    localparam int GAP = 4;
    localparam int DW  = BW * PR;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [3:0]    q_num;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] mem_in;
    logic [18:0]   inst;
    logic          busy;
    logic          done;

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;
    int done_cnt = 0;
    bit mon_en   = 1'b0;

    logic [18:0]   exp_inst_q[$];
    logic [DW-1:0] exp_mem_q[$];
    logic [DW-1:0] qv[16];
    logic [DW-1:0] kv[COL];

    fullchip_seq #(.bw(BW), .pr(PR), .col(COL), .gap_cyc(GAP)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .q_num    (q_num),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .mem_in   (mem_in),
        .inst     (inst),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Instruction word laid out from the documented bit map: [18] div ... [0] pmem_wr
    function automatic logic [18:0] mk(input bit dv, input bit ac, input bit ofr, input int qk,
                                       input int pa, input bit ex, input bit ld, input bit qrd,
                                       input bit qwr, input bit krd, input bit kwr, input bit pwr);
        logic [3:0] q4;
        logic [3:0] p4;
        q4 = 4'(qk);
        p4 = 4'(pa);
        return {dv, ac, ofr, q4, p4, ex, ld, qrd, qwr, krd, kwr, 1'b0, pwr};
    endfunction

    function automatic logic [DW-1:0] rnd_vec();
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic int exp_len(input int n);
        return (n + COL) + (COL + 2) + 2 * GAP + 3 * n + (n + 2) + 1;
    endfunction

    function automatic void build_expect(input int n);
        bit kr;
        exp_inst_q.delete();
        exp_mem_q.delete();
        for (int i = 0; i < 16; i++) qv[i] = rnd_vec();
        for (int i = 0; i < COL; i++) kv[i] = rnd_vec();
        for (int i = 0; i < n; i++) begin
            exp_inst_q.push_back(mk(0, 0, 0, i, 0, 0, 0, 0, 1, 0, 0, 0));
            exp_mem_q.push_back(qv[i]);
        end
        for (int i = 0; i < COL; i++) begin
            exp_inst_q.push_back(mk(0, 0, 0, i, 0, 0, 0, 0, 0, 0, 1, 0));
            exp_mem_q.push_back(kv[i]);
        end
        for (int c = 0; c <= COL + 1; c++) begin
            kr = (c >= 1 && c <= COL);
            exp_inst_q.push_back(mk(0, 0, 0, kr ? c - 1 : 0, 0, 0, 1, 0, 0, kr, 0, 0));
        end
        for (int i = 0; i < n; i++) exp_inst_q.push_back(mk(0, 0, 0, i, 0, 1, 0, 1, 0, 0, 0, 0));
        for (int i = 0; i < n; i++) exp_inst_q.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int c = 0; c <= n + 1; c++)
            exp_inst_q.push_back(mk(c <= n, 0, 0, 0, (c >= 2) ? c - 2 : 0, 0, 0, 0, 0, 0, 0, c >= 2));
    endfunction

    task automatic start_run(input int n, output int t0);
        @(posedge clk); #1;
        q_num = 4'(n - 1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        q_num = 4'($urandom);
        t0    = cyc;
    endtask

    task automatic send_beats(input int n, input bit stall);
        int g;
        bit ok;
        for (int b = 0; b < n + COL; b++) begin
            if (stall && b < n) begin
                in_valid = 1'b0;
                in_data  = rnd_vec();
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_data  = (b < n) ? qv[b] : kv[b - n];
            ok = 1'b0;
            g  = 0;
            while (!ok && g < 100) begin
                @(negedge clk);
                ok = in_ready;
                @(posedge clk); #1;
                g++;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int bound, output int t);
        t = -1;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                t = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int t0;
        reset = 1'b0; start = 1'b0; in_valid = 1'b0; q_num = 4'd0; in_data = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        n_checks++; if (inst !== 19'd0) begin n_fails++; $display("FAIL rst_inst: got %h, required 0", inst); end
        n_checks++; if (mem_in !== '0) begin n_fails++; $display("FAIL rst_mem_in: got %h, required 0", mem_in); end
        n_checks++; if (in_ready !== 1'b0) begin n_fails++; $display("FAIL rst_in_ready: got %b, required 0", in_ready); end
        n_checks++; if (busy !== 1'b0) begin n_fails++; $display("FAIL rst_busy: got %b, required 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fails++; $display("FAIL rst_done: got %b, required 0", done); end
        build_expect(8);
        start_run(8, t0);
        in_valid = 1'b1;
        for (int b = 0; b < 3; b++) begin
            in_data = qv[b];
            @(posedge clk); #1;
        end
        @(negedge clk);
        n_checks++;
        if (inst !== mk(0, 0, 0, 2, 0, 0, 0, 0, 1, 0, 0, 0))
            begin n_fails++; $display("FAIL pre_abort_inst: got %h, required %h", inst, mk(0, 0, 0, 2, 0, 0, 0, 0, 1, 0, 0, 0)); end
        reset = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (inst !== 19'd0) begin n_fails++; $display("FAIL abort_inst: got %h, required 0", inst); end
        n_checks++; if (mem_in !== '0) begin n_fails++; $display("FAIL abort_mem_in: got %h, required 0", mem_in); end
        n_checks++; if (in_ready !== 1'b0) begin n_fails++; $display("FAIL abort_in_ready: got %b, required 0", in_ready); end
        n_checks++; if (busy !== 1'b0) begin n_fails++; $display("FAIL abort_busy: got %b, required 0", busy); end
        @(posedge clk); #1 reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (inst !== 19'd0 || busy !== 1'b0 || in_ready !== 1'b0)
                begin n_fails++; $display("FAIL idle_after_abort: inst %h busy %b in_ready %b, required 0 0 0", inst, busy, in_ready); end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_nominal();
        int t0, td;
        build_expect(8);
        done_cnt = 0;
        mon_en = 1'b1;
        start_run(8, t0);
        send_beats(8, 1'b0);
        wait_done(300, td);
        n_checks++; if (td - t0 !== 69) begin n_fails++; $display("FAIL nominal_latency: got %0d, required 69", td - t0); end
        @(negedge clk);
        n_checks++; if (done !== 1'b0) begin n_fails++; $display("FAIL nominal_done_width: got %b, required 0", done); end
        n_checks++; if (busy !== 1'b0) begin n_fails++; $display("FAIL nominal_busy_end: got %b, required 0", busy); end
        n_checks++; if (exp_inst_q.size() !== 0) begin n_fails++; $display("FAIL nominal_leftover: got %0d words, required 0", exp_inst_q.size()); end
        n_checks++; if (done_cnt !== 1) begin n_fails++; $display("FAIL nominal_done_count: got %0d, required 1", done_cnt); end
        mon_en = 1'b0;
    endtask

    task automatic test_stalls();
        int t0, td;
        build_expect(8);
        done_cnt = 0;
        mon_en = 1'b1;
        start_run(8, t0);
        send_beats(8, 1'b1);
        wait_done(400, td);
        n_checks++; if (td < 0) begin n_fails++; $display("FAIL stall_timeout: got no done, required done"); end
        n_checks++; if (td - t0 !== exp_len(8) + 8) begin n_fails++; $display("FAIL stall_latency: got %0d, required %0d", td - t0, exp_len(8) + 8); end
        @(negedge clk);
        n_checks++; if (exp_inst_q.size() !== 0) begin n_fails++; $display("FAIL stall_leftover: got %0d words, required 0", exp_inst_q.size()); end
        mon_en = 1'b0;
    endtask

    task automatic test_qnum(input int n);
        int t0, td;
        build_expect(n);
        done_cnt = 0;
        mon_en = 1'b1;
        start_run(n, t0);
        send_beats(n, 1'b0);
        wait_done(400, td);
        n_checks++; if (td - t0 !== exp_len(n)) begin n_fails++; $display("FAIL q%0d_latency: got %0d, required %0d", n, td - t0, exp_len(n)); end
        @(negedge clk);
        n_checks++; if (exp_inst_q.size() !== 0) begin n_fails++; $display("FAIL q%0d_leftover: got %0d words, required 0", n, exp_inst_q.size()); end
        n_checks++; if (busy !== 1'b0) begin n_fails++; $display("FAIL q%0d_busy_end: got %b, required 0", n, busy); end
        mon_en = 1'b0;
    endtask

    task automatic test_start_in_exec();
        int t0, td;
        bit seen;
        build_expect(4);
        done_cnt = 0;
        mon_en = 1'b1;
        start_run(4, t0);
        send_beats(4, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = (inst[7] === 1'b1);
        end
        n_checks++; if (!seen) begin n_fails++; $display("FAIL exec_seen: got none, required execute word"); end
        n_checks++; if (busy !== 1'b1) begin n_fails++; $display("FAIL exec_busy: got %b, required 1", busy); end
        @(posedge clk); #1;
        start = 1'b1;
        q_num = 4'd9;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(300, td);
        n_checks++; if (td - t0 !== exp_len(4)) begin n_fails++; $display("FAIL exec_start_latency: got %0d, required %0d", td - t0, exp_len(4)); end
        repeat (40) @(negedge clk);
        n_checks++; if (done_cnt !== 1) begin n_fails++; $display("FAIL exec_start_done_count: got %0d, required 1", done_cnt); end
        n_checks++; if (busy !== 1'b0) begin n_fails++; $display("FAIL exec_start_busy_end: got %b, required 0", busy); end
        n_checks++; if (exp_inst_q.size() !== 0) begin n_fails++; $display("FAIL exec_start_leftover: got %0d words, required 0", exp_inst_q.size()); end
        mon_en = 1'b0;
    endtask

    initial begin
        logic [18:0]   e;
        logic [DW-1:0] em;
        fork
            forever begin
                @(negedge clk);
                if (mon_en) begin
                    if (done === 1'b1) done_cnt++;
                    if (inst !== 19'd0) begin
                        n_checks++;
                        if (exp_inst_q.size() == 0) begin
                            n_fails++;
                            $display("FAIL sb_unexpected_inst: got %h, required no word", inst);
                        end else begin
                            e = exp_inst_q.pop_front();
                            if (inst !== e) begin
                                n_fails++;
                                $display("FAIL sb_inst: got %h, required %h", inst, e);
                            end
                            if (e[4] | e[2]) begin
                                n_checks++;
                                em = (exp_mem_q.size() != 0) ? exp_mem_q.pop_front() : 'x;
                                if (mem_in !== em) begin
                                    n_fails++;
                                    $display("FAIL sb_mem_in: got %h, required %h", mem_in, em);
                                end
                            end
                        end
                    end
                end
            end
        join_none
        test_reset();
        test_nominal();
        test_stalls();
        test_qnum(1);
        test_qnum(16);
        test_start_in_exec();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
